iec_fast_serial: RTL and testbench

//  Parametrised burst/fast-serial engine for drive models: buffered MSB-first shifter on FCLK/DATA (open-collector, 1=released).

---
 rtl/iec_fast_serial.sv | 235 +++++++++++++++++++++++
 tb/tb_iec_fast_serial.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iec_fast_serial.sv
// Burst/fast-serial engine: MSB-first shifter on open-collector FCLK/DATA (1 = released),
// master or slave clocking, with TX/RX FIFOs between the CPU side and the bit timing.
module iec_fast_serial #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             master,
    input  logic             tx_en,
    input  logic             rx_req,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    input  logic             fclk_i,
    input  logic             data_i,
    output logic             fclk_o,
    output logic             data_o,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    input  logic             clr_status
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(WIDTH);
    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(DIV - 1);
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);

    typedef enum logic [2:0] {IDLE, M_LO, M_HI, S_SHIFT, DONE} state_t;

    state_t           state;
    logic             is_tx;
    logic [WIDTH-1:0] shifter;
    logic [BW-1:0]    bit_cnt;
    logic [TW-1:0]    tick_cnt;

    // Bus inputs are asynchronous; synchronisers reset to the released level so no false edge.
    logic fclk_s1, fclk_s2, fclk_d, data_s1, data_s2;
    logic fclk_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            fclk_s1 <= 1'b1;
            fclk_s2 <= 1'b1;
            fclk_d  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            fclk_s1 <= fclk_i;
            fclk_s2 <= fclk_s1;
            fclk_d  <= fclk_s2;
            data_s1 <= data_i;
            data_s2 <= data_s1;
        end
    end

    assign fclk_rise = fclk_s2 & ~fclk_d;

    // TX FIFO
    logic [WIDTH-1:0] tx_mem [DEPTH];
    logic [PW-1:0]    tx_wr, tx_rd;
    logic [CW-1:0]    tx_cnt;
    logic             tx_push, tx_pop, tx_empty;
    logic [WIDTH-1:0] tx_head;

    assign tx_ready = (tx_cnt != FULL);
    assign tx_empty = (tx_cnt == '0);
    assign tx_push  = tx_valid & tx_ready;
    assign tx_head  = tx_mem[tx_rd];
    assign tx_pop   = (state == IDLE) && tx_en && !tx_empty && (!master || ce);

    // NOTE: storage arrays carry no reset; emptiness is defined solely by the reset counts.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + PW'(1);
            if (tx_pop)  tx_rd <= tx_rd + PW'(1);
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
        end
    end

    // RX FIFO
    logic [WIDTH-1:0] rx_mem [DEPTH];
    logic [PW-1:0]    rx_wr, rx_rd;
    logic [CW-1:0]    rx_cnt;
    logic             rx_full, rx_push, rx_pop, rx_drop;

    assign rx_full  = (rx_cnt == FULL);
    assign rx_valid = (rx_cnt != '0);
    assign rx_data  = rx_mem[rx_rd];
    assign rx_pop   = rx_valid & rx_ready;
    assign rx_push  = (state == DONE) && !is_tx && !rx_full;
    assign rx_drop  = (state == DONE) && !is_tx && rx_full;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr] <= shifter;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + PW'(1);
            if (rx_pop)  rx_rd <= rx_rd + PW'(1);
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
        end
    end

    // NOTE: all state below is written with <= so every branch sees the pre-edge values;
    // a later assignment in the same branch deliberately overrides an earlier one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            is_tx    <= 1'b0;
            shifter  <= '0;
            bit_cnt  <= '0;
            tick_cnt <= '0;
            fclk_o   <= 1'b1;
            data_o   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (rx_drop)         overrun <= 1'b1;
            else if (clr_status) overrun <= 1'b0;

            case (state)
                IDLE: begin
                    fclk_o   <= 1'b1;
                    data_o   <= 1'b1;
                    bit_cnt  <= '0;
                    tick_cnt <= '0;
                    if (tx_pop) begin
                        shifter <= tx_head;
                        data_o  <= tx_head[WIDTH-1];
                        is_tx   <= 1'b1;
                        busy    <= 1'b1;
                        if (master) begin
                            state  <= M_LO;
                            fclk_o <= 1'b0;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end else if (master && !tx_en && rx_req && !rx_full && ce) begin
                        state  <= M_LO;
                        fclk_o <= 1'b0;
                        is_tx  <= 1'b0;
                        busy   <= 1'b1;
                    end else if (!master && !tx_en) begin
                        state <= S_SHIFT;
                        is_tx <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                M_LO: begin
                    if (ce) begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= '0;
                            state    <= M_HI;
                            fclk_o   <= 1'b1;
                            if (!is_tx) shifter <= {shifter[WIDTH-2:0], data_s2};
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                M_HI: begin
                    if (ce) begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= '0;
                            if (is_tx) begin
                                shifter <= {shifter[WIDTH-2:0], 1'b0};
                                data_o  <= shifter[WIDTH-2];
                            end
                            if (bit_cnt == LAST_BIT) begin
                                state  <= DONE;
                                done   <= 1'b1;
                                data_o <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                                state   <= M_LO;
                                fclk_o  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                S_SHIFT: begin
                    fclk_o <= 1'b1;
                    if (fclk_rise) begin
                        if (is_tx) begin
                            shifter <= {shifter[WIDTH-2:0], 1'b0};
                            data_o  <= shifter[WIDTH-2];
                        end else begin
                            shifter <= {shifter[WIDTH-2:0], data_s2};
                        end
                        if (bit_cnt == LAST_BIT) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            data_o <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    fclk_o <= 1'b1;
                    data_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iec_fast_serial.sv
// Self-checking bench for iec_fast_serial (WIDTH=8, DEPTH=4, DIV=2): master/slave TX/RX,
// FIFO limits, overrun and mid-byte reset, with expectations built from byte-level models.
module tb_iec_fast_serial;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int DV = 2;

    logic         clk = 1'b0;
    logic         reset, ce, master, tx_en, rx_req;
    logic [W-1:0] tx_data;
    logic         tx_valid, tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid, rx_ready;
    logic         fclk_i, data_i, fclk_o, data_o;
    logic         busy, done, overrun, clr_status;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit ce_slow = 1'b0;

    iec_fast_serial #(.WIDTH(W), .DEPTH(D), .DIV(DV)) dut (
        .clk(clk), .reset(reset), .ce(ce), .master(master), .tx_en(tx_en), .rx_req(rx_req),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .fclk_i(fclk_i), .data_i(data_i), .fclk_o(fclk_o), .data_o(data_o),
        .busy(busy), .done(done), .overrun(overrun), .clr_status(clr_status)
    );

    always #5 clk = ~clk;

    // ce is either always high or high on every other clock
    initial begin
        ce = 1'b1;
        forever begin
            @(negedge clk);
            ce = ce_slow ? ~ce : 1'b1;
        end
    end

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic m, input logic te, input logic rq, input logic d0);
        master = m; tx_en = te; rx_req = rq; data_i = d0; fclk_i = 1'b1;
        tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0; clr_status = 1'b0; ce_slow = 1'b0;
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] v);
        tx_data = v; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic pop();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic wait_fclk(input logic lvl, output int cycles, output bit timeout);
        cycles = 0; timeout = 1'b0;
        while (fclk_o !== lvl) begin
            @(negedge clk);
            cycles++;
            if (cycles > 200) begin
                timeout = 1'b1;
                break;
            end
        end
    endtask

    // Records data_o at every fclk_o rise and the length of every low/high phase.
    task automatic capture_master(input int half, output logic [W-1:0] bits, output int bad, output bit to);
        int c; bit t;
        bits = '0; bad = 0; to = 1'b0;
        for (int i = 0; i < W; i++) begin
            wait_fclk(1'b0, c, t); to |= t;
            wait_fclk(1'b1, c, t); to |= t;
            if (c != half) bad++;
            bits = {bits[W-2:0], data_o};
            if (i < W - 1) begin
                wait_fclk(1'b0, c, t); to |= t;
                if (c != half) bad++;
            end
        end
    endtask

    task automatic slave_send(input logic [W-1:0] v);
        for (int i = W - 1; i >= 0; i--) begin
            data_i = v[i]; fclk_i = 1'b0; cyc(3);
            fclk_i = 1'b1; cyc(3);
        end
        cyc(3);
    endtask

    task automatic test_reset();
        do_reset(1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (fclk_o !== 1'b1)   begin errors++; $display("FAIL reset_fclk_o: got %b expected 1", fclk_o); end
        checks++; if (data_o !== 1'b1)   begin errors++; $display("FAIL reset_data_o: got %b expected 1", data_o); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (overrun !== 1'b0)  begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    endtask

    task automatic test_master_tx(input logic [W-1:0] v, input bit slow);
        logic [W-1:0] bits; int bad; bit to; int dc0; int half;
        half = slow ? 2 * DV : DV;
        do_reset(1'b1, 1'b1, 1'b0, 1'b1);
        ce_slow = slow;
        dc0 = done_cnt;
        push(v);
        capture_master(half, bits, bad, to);
        cyc(8);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL master_tx_timeout: fclk_o edges missing for byte %h", v); end
        checks++; if (bits !== v)  begin errors++; $display("FAIL master_tx_bits: got %h expected %h", bits, v); end
        checks++; if (bad != 0)    begin errors++; $display("FAIL master_tx_timing: %0d phases not %0d clk long", bad, half); end
        checks++; if (done_cnt - dc0 != 1) begin errors++; $display("FAIL master_tx_done: got %0d pulses expected 1", done_cnt - dc0); end
        checks++; if (busy !== 1'b0 || fclk_o !== 1'b1 || data_o !== 1'b1) begin
            errors++; $display("FAIL master_tx_idle: busy=%b fclk_o=%b data_o=%b expected 0 1 1", busy, fclk_o, data_o);
        end
    endtask

    task automatic test_slave_rx();
        logic [W-1:0] bytes [2]; bit seen;
        bytes[0] = 8'h3C; bytes[1] = 8'($urandom);
        do_reset(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(2);
        for (int j = 0; j < 2; j++) begin
            for (int i = W - 1; i >= 0; i--) begin
                data_i = bytes[j][i]; fclk_i = 1'b0; cyc(3);
                fclk_i = 1'b1;
                if (i > 0) cyc(3);
            end
            seen = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (rx_valid === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            checks++; if (!seen) begin errors++; $display("FAIL slave_rx_valid byte %0d: got %b within 4 clk expected 1", j, rx_valid); end
            checks++; if (rx_data !== bytes[j]) begin errors++; $display("FAIL slave_rx_data byte %0d: got %h expected %h", j, rx_data, bytes[j]); end
            pop();
            checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL slave_rx_pop byte %0d: rx_valid=%b expected 0", j, rx_valid); end
            cyc(2);
        end
    endtask

    task automatic test_overrun();
        logic [W-1:0] q [$]; logic [W-1:0] exp_v; bit exp_ovr;
        exp_ovr = 1'b0;
        do_reset(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(2);
        for (int v = 1; v <= 5; v++) begin
            slave_send(8'(v));
            if (q.size() < D) q.push_back(8'(v));
            else exp_ovr = 1'b1;
        end
        checks++; if (overrun !== exp_ovr) begin errors++; $display("FAIL overrun_set: got %b expected %b", overrun, exp_ovr); end
        while (q.size() > 0) begin
            exp_v = q.pop_front();
            checks++; if (rx_valid !== 1'b1 || rx_data !== exp_v) begin
                errors++; $display("FAIL overrun_pop: rx_valid=%b rx_data=%h expected 1 %h", rx_valid, rx_data, exp_v);
            end
            pop();
        end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL overrun_empty: rx_valid=%b expected 0", rx_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
        clr_status = 1'b1; cyc(1); clr_status = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b expected 0", overrun); end
    endtask

    task automatic test_tx_fifo_full();
        logic [W-1:0] q [$]; logic [W-1:0] v, bits; bit exp_ready; int bad; bit to;
        do_reset(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            v = 8'($urandom);
            exp_ready = (q.size() < D);
            checks++; if (tx_ready !== exp_ready) begin errors++; $display("FAIL fifo_tx_ready push %0d: got %b expected %b", i, tx_ready, exp_ready); end
            push(v);
            if (exp_ready) q.push_back(v);
        end
        checks++; if (tx_ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL fifo_full_idle: tx_ready=%b busy=%b expected 0 0", tx_ready, busy);
        end
        tx_en = 1'b1;
        while (q.size() > 0) begin
            v = q.pop_front();
            capture_master(DV, bits, bad, to);
            checks++; if (to !== 1'b0 || bits !== v || bad != 0) begin
                errors++; $display("FAIL fifo_drain: got %h (timeout %b, bad phases %0d) expected %h", bits, to, bad, v);
            end
        end
        cyc(20);
        checks++; if (busy !== 1'b0 || fclk_o !== 1'b1 || tx_ready !== 1'b1) begin
            errors++; $display("FAIL fifo_no_fifth: busy=%b fclk_o=%b tx_ready=%b expected 0 1 1", busy, fclk_o, tx_ready);
        end
    endtask

    task automatic test_master_rx();
        logic [W-1:0] b [2]; int c; bit t, to;
        b[0] = 8'h81; b[1] = 8'($urandom);
        to = 1'b0;
        do_reset(1'b1, 1'b0, 1'b1, b[0][W-1]);
        for (int j = 0; j < 2; j++) begin
            for (int i = W - 1; i >= 0; i--) begin
                wait_fclk(1'b0, c, t); to |= t;
                wait_fclk(1'b1, c, t); to |= t;
                if (i > 0) data_i = b[j][i-1];
                else if (j == 0) data_i = b[1][W-1];
                if (j == 1 && i == 4) rx_req = 1'b0;
            end
        end
        cyc(6);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL master_rx_timeout: fclk_o edges missing"); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== b[0]) begin
            errors++; $display("FAIL master_rx_first: rx_valid=%b rx_data=%h expected 1 %h", rx_valid, rx_data, b[0]);
        end
        pop();
        checks++; if (rx_valid !== 1'b1 || rx_data !== b[1]) begin
            errors++; $display("FAIL master_rx_second: rx_valid=%b rx_data=%h expected 1 %h", rx_valid, rx_data, b[1]);
        end
        pop();
        cyc(20);
        checks++; if (rx_valid !== 1'b0 || busy !== 1'b0 || fclk_o !== 1'b1) begin
            errors++; $display("FAIL master_rx_stop: rx_valid=%b busy=%b fclk_o=%b expected 0 0 1", rx_valid, busy, fclk_o);
        end
    endtask

    task automatic test_slave_tx();
        logic [W-1:0] v, bits; int dc0;
        v = 8'($urandom);
        do_reset(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(2);
        dc0 = done_cnt;
        fclk_i = 1'b0; cyc(3); fclk_i = 1'b1; cyc(4);
        checks++; if (busy !== 1'b0 || data_o !== 1'b1 || done_cnt != dc0) begin
            errors++; $display("FAIL slave_tx_empty: busy=%b data_o=%b done pulses=%0d expected 0 1 0", busy, data_o, done_cnt - dc0);
        end
        push(v);
        cyc(4);
        bits = '0;
        for (int i = 0; i < W; i++) begin
            fclk_i = 1'b0; cyc(3);
            bits = {bits[W-2:0], data_o};
            fclk_i = 1'b1; cyc(3);
        end
        cyc(4);
        checks++; if (bits !== v) begin errors++; $display("FAIL slave_tx_bits: got %h expected %h", bits, v); end
        checks++; if (done_cnt - dc0 != 1 || busy !== 1'b0 || data_o !== 1'b1) begin
            errors++; $display("FAIL slave_tx_end: done pulses=%0d busy=%b data_o=%b expected 1 0 1", done_cnt - dc0, busy, data_o);
        end
    endtask

    task automatic test_reset_mid_byte();
        int c; bit t, to;
        to = 1'b0;
        do_reset(1'b1, 1'b1, 1'b0, 1'b1);
        push(8'($urandom)); push(8'($urandom)); push(8'($urandom));
        for (int i = 0; i < 3; i++) begin
            wait_fclk(1'b0, c, t); to |= t;
            wait_fclk(1'b1, c, t); to |= t;
        end
        cyc(1);
        checks++; if (to !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL midreset_active: busy=%b timeout=%b expected 1 0", busy, to); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (fclk_o !== 1'b1 || data_o !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1 || rx_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_release: fclk_o=%b data_o=%b busy=%b tx_ready=%b rx_valid=%b expected 1 1 0 1 0",
                               fclk_o, data_o, busy, tx_ready, rx_valid);
        end
        reset = 1'b0;
        cyc(10);
        checks++; if (busy !== 1'b0 || fclk_o !== 1'b1) begin
            errors++; $display("FAIL midreset_fifo_cleared: busy=%b fclk_o=%b expected 0 1", busy, fclk_o);
        end
    endtask

    initial begin
        test_reset();
        test_master_tx(8'hA5, 1'b0);
        test_master_tx(8'($urandom), 1'b0);
        test_master_tx(8'($urandom), 1'b1);
        test_slave_rx();
        test_overrun();
        test_tx_fifo_full();
        test_master_rx();
        test_slave_tx();
        test_reset_mid_byte();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
